// File: rtl/win_pkg.sv
// Shared constants, state encoding and window packing for the 3x3 window generator.
// Field offsets give the bit position of each neighbour inside the 108-bit window word.
package win_pkg;

  localparam int unsigned PIX_W = 12;
  localparam int unsigned WIN_W = 9 * PIX_W;

  localparam int unsigned WIN_CENTER = 96;
  localparam int unsigned WIN_LEFT   = 84;
  localparam int unsigned WIN_RIGHT  = 72;
  localparam int unsigned WIN_UP     = 60;
  localparam int unsigned WIN_DOWN   = 48;
  localparam int unsigned WIN_UL     = 36;
  localparam int unsigned WIN_UR     = 24;
  localparam int unsigned WIN_DL     = 12;
  localparam int unsigned WIN_DR     = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StRun  = 2'd2
  } win_state_e;

  // One window column: up = row y-2, mid = row y-1, down = row y.
  typedef struct packed {
    logic [PIX_W-1:0] up;
    logic [PIX_W-1:0] mid;
    logic [PIX_W-1:0] down;
  } win_col_t;

  function automatic logic [WIN_W-1:0] pack_window(input win_col_t l, input win_col_t c,
                                                   input win_col_t r);
    logic [WIN_W-1:0] w;
    w = '0;
    w[WIN_CENTER +: PIX_W] = c.mid;
    w[WIN_LEFT   +: PIX_W] = l.mid;
    w[WIN_RIGHT  +: PIX_W] = r.mid;
    w[WIN_UP     +: PIX_W] = c.up;
    w[WIN_DOWN   +: PIX_W] = c.down;
    w[WIN_UL     +: PIX_W] = l.up;
    w[WIN_UR     +: PIX_W] = r.up;
    w[WIN_DL     +: PIX_W] = l.down;
    w[WIN_DR     +: PIX_W] = r.down;
    return w;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port line buffer: read-before-write at one address, 1-cycle registered read.
// Read data hold while en_i is low; only the read register is reset.
module line_buffer #(
  parameter  int unsigned DEPTH = 320,
  parameter  int unsigned WIDTH = 12,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en_i) begin
      rdata_d = mem[addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator over a raster RGB444 stream.
// Emits one packed window per interior pixel, one cycle after the pixel is accepted.
module window_gen_3x3
  import win_pkg::*;
#(
  parameter  int unsigned IMG_W = 320,
  parameter  int unsigned IMG_H = 240,
  localparam int unsigned XW    = $clog2(IMG_W),
  localparam int unsigned YW    = $clog2(IMG_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_in,
  output logic [9*PIX_W-1:0] color_data,
  output logic               window_valid,
  output logic [XW-1:0]      cx,
  output logic [YW-1:0]      cy,
  output logic               frame_done
);

  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);

  win_state_e       state_q, state_d;
  logic [XW-1:0]    x_q, x_d, px;
  logic [YW-1:0]    y_q, y_d, py;
  logic             accept, emit, last_pix;
  logic             par_q, par_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [PIX_W-1:0] rd0, rd1;
  win_col_t         col0_q, col0_d, col1_q, col1_d, col2;
  logic             wv_q, wv_d, fd_q, fd_d;
  logic [XW-1:0]    cx_q, cx_d;
  logic [YW-1:0]    cy_q, cy_d;

  // Coordinates of the pixel on the input this cycle; frame_start forces the origin.
  always_comb begin
    accept   = pix_valid && (frame_start || (state_q != StIdle));
    px       = frame_start ? '0 : x_q;
    py       = frame_start ? '0 : y_q;
    last_pix = (px == XLast) && (py == YLast);
    emit     = accept && (px >= XW'(2)) && (py >= YW'(2));
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    if (accept) begin
      if (last_pix) begin
        state_d = StIdle;
        x_d     = '0;
        y_d     = '0;
      end else begin
        state_d = (py >= YW'(2)) ? StRun : StFill;
        if (px == XLast) begin
          x_d = '0;
          y_d = py + YW'(1);
        end else begin
          x_d = px + XW'(1);
          y_d = py;
        end
      end
    end
  end

  // Buffers alternate by row parity: the one written this row returns row y-2 through
  // read-before-write, the other still holds row y-1, so neither needs a second port.
  always_comb begin
    col2.up   = par_q ? rd1 : rd0;
    col2.mid  = par_q ? rd0 : rd1;
    col2.down = pix_q;
  end

  always_comb begin
    pix_d  = pix_q;
    par_d  = par_q;
    col0_d = col0_q;
    col1_d = col1_q;
    cx_d   = cx_q;
    cy_d   = cy_q;
    if (accept) begin
      pix_d  = pix_in;
      par_d  = py[0];
      col0_d = col1_q;
      col1_d = col2;
    end
    if (emit) begin
      cx_d = px - XW'(1);
      cy_d = py - YW'(1);
    end
    wv_d = emit;
    fd_d = emit && last_pix;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      par_q   <= 1'b0;
      pix_q   <= '0;
      col0_q  <= '0;
      col1_q  <= '0;
      wv_q    <= 1'b0;
      fd_q    <= 1'b0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      par_q   <= par_d;
      pix_q   <= pix_d;
      col0_q  <= col0_d;
      col1_q  <= col1_d;
      wv_q    <= wv_d;
      fd_q    <= fd_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
    end
  end

  line_buffer #(
    .DEPTH(IMG_W),
    .WIDTH(PIX_W)
  ) u_lb0 (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (accept),
    .we_i   (!py[0]),
    .addr_i (px),
    .wdata_i(pix_in),
    .rdata_o(rd0)
  );

  line_buffer #(
    .DEPTH(IMG_W),
    .WIDTH(PIX_W)
  ) u_lb1 (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (accept),
    .we_i   (py[0]),
    .addr_i (px),
    .wdata_i(pix_in),
    .rdata_o(rd1)
  );

  assign color_data   = pack_window(col0_q, col1_q, col2);
  assign window_valid = wv_q;
  assign frame_done   = fd_q;
  assign cx           = cx_q;
  assign cy           = cy_q;

endmodule
